// File: rtl/load_align_unit_pkg.sv
// Purpose: shared funct3 load codes, FSM state encoding and load-type decode helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package load_align_unit_pkg;

   // funct3 load codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   // 111 is never a load; LD and LWU only exist on a 64-bit data path.
   function automatic logic f3_illegal(input logic [2:0] f3, input int xlen);
      return (f3 == 3'b111) || ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
   endfunction

   // Access size in bytes: 1, 2, 4 or 8, encoded by funct3[1:0].
   function automatic logic [3:0] f3_size(input logic [2:0] f3);
      return 4'd1 << f3[1:0];
   endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Purpose: shift the {high,low} word pair down by the byte offset, truncate to the access size, extend.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   lo, hi  in  XLEN       first and second memory words (hi unused unless the load crosses a word)
//   offset  in  log2(B)    byte offset of the load inside the first word
//   funct3  in  3          load type; bit 2 selects zero extension, bits 1:0 the size
//   data    out XLEN       aligned, extended result
module load_extract #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]              lo,
   input  logic [XLEN-1:0]              hi,
   input  logic [$clog2(XLEN/8)-1:0]    offset,
   input  logic [2:0]                   funct3,
   output logic [XLEN-1:0]              data
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic            sign;

   // Byte offset times eight gives the bit shift of the concatenated pair.
   assign shifted = XLEN'({hi, lo} >> {offset, 3'b000});

   always_comb begin
      keep = '1;
      sign = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            keep = XLEN'(8'hFF);
            sign = shifted[7];
         end
         2'b01: begin
            keep = XLEN'(16'hFFFF);
            sign = shifted[15];
         end
         2'b10: begin
            keep = XLEN'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: begin
            // Full-width load: nothing to truncate or extend.
            keep = '1;
            sign = 1'b0;
         end
      endcase
   end

   // Unsigned variants (funct3[2]=1) never fill the upper bits.
   assign data = (shifted & keep) | ((sign && !funct3[2]) ? ~keep : '0);

endmodule

// File: rtl/load_align_unit.sv
// Purpose: accept one load, fetch one or two aligned memory words, return aligned/extended data or an error.
// Latency: accept N -> rsp_valid N+3 (N+5 when split, N+1 on error) with a zero-wait memory.
// Backpressure: req_ready only in IDLE; mem_req and rsp held stable until their ready is seen.
//
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr/req_funct3  load request handshake, byte address, load type
//   mem_req_valid/mem_req_ready/mem_addr     word-aligned read request to memory
//   mem_rvalid/mem_rdata                     read data return (one beat per request)
//   rsp_valid/rsp_ready/rsp_data/rsp_err     load response handshake
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   input  logic [2:0]      req_funct3,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_err
);

   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);

   state_t          state, state_nxt;

   logic [OFFW-1:0] offset_q;
   logic [2:0]      funct3_q;
   logic            split_q;
   logic            err_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] mem_addr_q;
   logic [XLEN-1:0] extract_data;

   // Request decode, evaluated on the incoming request while IDLE.
   logic [OFFW-1:0] req_off;
   logic [4:0]      req_span;
   logic            req_split;
   logic            req_err;
   logic            accept;

   assign req_off   = req_addr[OFFW-1:0];
   assign req_span  = 5'(req_off) + 5'(f3_size(req_funct3));
   assign req_split = (req_span > 5'(BYTES));
   assign req_err   = f3_illegal(req_funct3, XLEN) || (req_split && !MISALIGN_EN);
   assign accept    = req_valid && (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs. mem_rvalid is only looked at in the WAIT states.
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      rsp_valid     = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_err ? ST_RESP : ST_REQ0;
            end
         end
         ST_REQ0: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_nxt = ST_WAIT0;
            end
         end
         ST_WAIT0: begin
            if (mem_rvalid) begin
               state_nxt = split_q ? ST_REQ1 : ST_RESP;
            end
         end
         ST_REQ1: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_nxt = ST_WAIT1;
            end
         end
         ST_WAIT1: begin
            if (mem_rvalid) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Per-load context and captured memory words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset_q   <= '0;
         funct3_q   <= '0;
         split_q    <= 1'b0;
         err_q      <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         mem_addr_q <= '0;
      end else begin
         if (accept) begin
            offset_q   <= req_off;
            funct3_q   <= req_funct3;
            split_q    <= req_split;
            err_q      <= req_err;
            lo_q       <= '0;
            hi_q       <= '0;
            mem_addr_q <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
         end
         if ((state == ST_WAIT0) && mem_rvalid) begin
            lo_q <= mem_rdata;
            // Advance to the next word now; mem_req_valid is low here so the bus sees no change
            // during a pending request. Wraps naturally at the top of the address space.
            if (split_q) begin
               mem_addr_q <= mem_addr_q + XLEN'(BYTES);
            end
         end
         if ((state == ST_WAIT1) && mem_rvalid) begin
            hi_q <= mem_rdata;
         end
      end
   end

   load_extract #(
      .XLEN(XLEN)
   ) u_extract (
      .lo     (lo_q),
      .hi     (hi_q),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (extract_data)
   );

   // Response fields come straight from registers, so they stay stable for the whole RESP state.
   assign mem_addr = mem_addr_q;
   assign rsp_err  = rsp_valid && err_q;
   assign rsp_data = (rsp_valid && !err_q) ? extract_data : '0;

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Index 0: MISALIGN_EN=1, index 1: MISALIGN_EN=0. Both XLEN=32.
   logic [1:0]       req_valid, req_ready, mem_req_valid, mem_req_ready;
   logic [1:0]       mem_rvalid, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][31:0] req_addr, mem_addr, mem_rdata, rsp_data;
   logic [1:0][2:0]  req_funct3;

   load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]), .req_funct3(req_funct3[0]),
      .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]), .mem_addr(mem_addr[0]),
      .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
   );

   load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
      .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]), .mem_addr(mem_addr[1]),
      .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Byte-addressed memory image; unknown bytes are filled randomly on first touch.
   logic [7:0] mem_b [logic [31:0]];

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (!mem_b.exists(a)) mem_b[a] = 8'($urandom);
      return mem_b[a];
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
   endfunction

   task automatic put_word(input logic [31:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) mem_b[a + 32'(k)] = w[8*k +: 8];
   endtask

   // Issue one load on instance idx, play memory and consumer, check against the byte-level model.
   task automatic run_load(input int idx, input logic [31:0] addr, input logic [2:0] f3,
                           input int mstall, input int rstall, output logic [31:0] got);
      int unsigned size, off;
      bit          illegal, split, exp_err;
      logic [63:0] v;
      logic [31:0] exp_a [$];
      int          exp_lat, cyc, n_req, n_rsp, first_rsp, stall, rstl, waitc;
      bit          rv_pend, addr_ok, rsp_ok, busy_ok, prev_pend;
      logic [31:0] rv_addr, prev_addr, first_data;
      logic        first_err;
      string       pfx;

      pfx     = $sformatf("u%0d_f3=%0d_a=%0h", idx, f3, addr);
      size    = 1 << f3[1:0];
      off     = addr % 4;
      illegal = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110);
      split   = (off + size) > 4;
      exp_err = illegal || (split && idx == 1);
      v = '0;
      if (!exp_err) begin
         for (int k = 0; k < int'(size); k++) v |= 64'(rd_byte(addr + 32'(k))) << (8*k);
         if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((64'd1 << (8*size)) - 64'd1);
         exp_a.push_back(addr & ~32'd3);
         if (split) exp_a.push_back((addr & ~32'd3) + 32'd4);
      end
      exp_lat = exp_err ? 1 : (split ? 5 : 3);

      waitc = 0;
      @(negedge clk);
      while (!req_ready[idx] && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk_eq({pfx, "_idle_before"}, req_ready[idx], 1);
      req_valid[idx]  = 1'b1;
      req_addr[idx]   = addr;
      req_funct3[idx] = f3;

      cyc = 0; n_req = 0; n_rsp = 0; first_rsp = -1; stall = 0; rstl = 0;
      rv_pend = 0; addr_ok = 1; rsp_ok = 1; busy_ok = 1; prev_pend = 0;
      rv_addr = '0; prev_addr = '0; first_data = '0; first_err = 1'b0;
      while (n_rsp == 0 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         req_valid[idx]  = 1'b0;
         req_addr[idx]   = $urandom;
         req_funct3[idx] = 3'($urandom);
         mem_rvalid[idx] = 1'b0;
         if (rv_pend) begin
            mem_rvalid[idx] = 1'b1;
            mem_rdata[idx]  = rd_word(rv_addr);
            rv_pend = 0;
         end else if ($urandom_range(3) == 0) begin
            // stray beat while not waiting: must be ignored
            mem_rvalid[idx] = 1'b1;
            mem_rdata[idx]  = $urandom;
         end
         if (req_ready[idx]) busy_ok = 0;
         if (mem_req_valid[idx]) begin
            if (prev_pend && mem_addr[idx] != prev_addr) addr_ok = 0;
            if (stall < mstall) begin
               mem_req_ready[idx] = 1'b0;
               stall++;
               prev_pend = 1;
               prev_addr = mem_addr[idx];
            end else begin
               mem_req_ready[idx] = 1'b1;
               if (n_req < exp_a.size())
                  chk_eq($sformatf("%s_mem_addr%0d", pfx, n_req), mem_addr[idx], exp_a[n_req]);
               n_req++;
               rv_pend = 1;
               rv_addr = mem_addr[idx];
               prev_pend = 0;
               stall = 0;
            end
         end else begin
            mem_req_ready[idx] = 1'($urandom);
         end
         if (rsp_valid[idx]) begin
            if (first_rsp < 0) begin
               first_rsp  = cyc;
               first_data = rsp_data[idx];
               first_err  = rsp_err[idx];
            end else if (rsp_data[idx] != first_data || rsp_err[idx] != first_err) begin
               rsp_ok = 0;
            end
            if (rstl < rstall) begin
               rsp_ready[idx] = 1'b0;
               rstl++;
            end else begin
               rsp_ready[idx] = 1'b1;
               n_rsp++;
            end
         end else begin
            rsp_ready[idx] = 1'($urandom);
         end
      end

      @(negedge clk);
      rsp_ready[idx]     = 1'b0;
      mem_req_ready[idx] = 1'b0;
      mem_rvalid[idx]    = 1'b0;
      chk_eq({pfx, "_idle_after"}, {rsp_valid[idx], req_ready[idx], mem_req_valid[idx]}, 3'b010);
      chk_eq({pfx, "_rsp_count"}, n_rsp, 1);
      chk_eq({pfx, "_rsp_data"}, first_data, v[31:0]);
      chk_eq({pfx, "_rsp_err"}, first_err, exp_err);
      chk_eq({pfx, "_mem_req_count"}, n_req, exp_a.size());
      chk_eq({pfx, "_req_ready_low"}, busy_ok, 1);
      chk_eq({pfx, "_mem_addr_hold"}, addr_ok, 1);
      chk_eq({pfx, "_rsp_hold"}, rsp_ok, 1);
      if (mstall == 0 && rstall == 0) chk_eq({pfx, "_latency"}, first_rsp, exp_lat);
      got = first_data;
   endtask

   // Reset while waiting for read data, then a late beat: no response may appear.
   task automatic reset_mid_wait();
      bit quiet;
      int waitc;
      waitc = 0;
      @(negedge clk);
      while (!req_ready[0] && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      req_valid[0]     = 1'b1;
      req_addr[0]      = 32'h300;
      req_funct3[0]    = 3'b010;
      mem_req_ready[0] = 1'b1;
      mem_rvalid[0]    = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk_eq("rst_req0_valid", mem_req_valid[0], 1);
      @(negedge clk);
      mem_req_ready[0] = 1'b0;
      rst_n = 1'b0;
      #2;
      chk_eq("rst_async_ready", req_ready[0], 1);
      #1;
      rst_n = 1'b1;
      mem_rvalid[0] = 1'b1;
      mem_rdata[0]  = 32'hDEAD_BEEF;
      quiet = 1;
      repeat (4) begin
         @(negedge clk);
         mem_rvalid[0] = 1'b0;
         if (rsp_valid[0] || mem_req_valid[0]) quiet = 0;
      end
      chk_eq("rst_no_rsp", quiet, 1);
      chk_eq("rst_idle_ready", req_ready[0], 1);
   endtask

   initial begin
      logic [31:0] got;
      int          idx, mst, rst;
      logic [31:0] addr;
      logic [2:0]  f3;

      rst_n = 1'b0;
      req_valid = '0; req_addr = '0; req_funct3 = '0;
      mem_req_ready = '0; mem_rvalid = '0; mem_rdata = '0; rsp_ready = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk_eq($sformatf("u%0d_reset_req_ready", i), req_ready[i], 1);
         chk_eq($sformatf("u%0d_reset_mem_req_valid", i), mem_req_valid[i], 0);
         chk_eq($sformatf("u%0d_reset_rsp_valid", i), rsp_valid[i], 0);
         chk_eq($sformatf("u%0d_reset_rsp_err", i), rsp_err[i], 0);
         chk_eq($sformatf("u%0d_reset_rsp_data", i), rsp_data[i], 0);
         chk_eq($sformatf("u%0d_reset_mem_addr", i), mem_addr[i], 0);
      end
      rst_n = 1'b1;

      put_word(32'h100, 32'h8000_00F0);
      run_load(0, 32'h100, 3'b010, 0, 0, got);
      chk_eq("lw_aligned_value", got, 32'h8000_00F0);

      put_word(32'h100, 32'hAABB_CCDD);
      put_word(32'h104, 32'h1122_3344);
      run_load(0, 32'h103, 3'b001, 0, 0, got);
      chk_eq("lh_split_value", got, 32'h0000_44AA);

      put_word(32'h100, 32'h00F5_0000);
      run_load(0, 32'h102, 3'b100, 0, 0, got);
      chk_eq("lbu_value", got, 32'h0000_00F5);
      run_load(0, 32'h102, 3'b000, 0, 0, got);
      chk_eq("lb_value", got, 32'hFFFF_FFF5);

      run_load(0, 32'h100, 3'b011, 0, 0, got);
      chk_eq("ld_err_data", got, 32'h0);
      run_load(1, 32'h101, 3'b010, 0, 0, got);
      chk_eq("lw_misaligned_off_data", got, 32'h0);
      run_load(1, 32'h101, 3'b001, 0, 0, got);

      put_word(32'h200, 32'h1234_5678);
      run_load(0, 32'h200, 3'b010, 3, 4, got);
      chk_eq("lw_stalled_value", got, 32'h1234_5678);

      reset_mid_wait();

      for (int n = 0; n < 300; n++) begin
         idx = int'($urandom_range(1));
         case ($urandom_range(3))
            0:       addr = 32'h1000 + 32'($urandom_range(63));
            1:       addr = 32'hFFFF_FFF8 + 32'($urandom_range(7));
            default: addr = $urandom;
         endcase
         f3  = 3'($urandom_range(7));
         mst = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
         rst = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
         run_load(idx, addr, f3, mst, rst, got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
